// File: rtl/roachf_mcnt_pkg.sv
`default_nettype none
//==============================================================================
// Module      : roachf_mcnt_pkg
// Description : Shared types and constants for the F-engine master-counter
//               generator. Holds the controller state encoding, default
//               spectrum length and counter width, and the width of the MSB
//               word exposed to software.
// Revision    : 1.0 - initial release
//==============================================================================
package roachf_mcnt_pkg;

    // Controller states. Explicit 2-bit encoding so the register width is
    // fixed regardless of tool defaults.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } mcnt_state_t;

    // 1024 channels at 4 per clock.
    localparam int SPEC_LEN_DEFAULT   = 256;
    localparam int MCNT_WIDTH_DEFAULT = 48;

    // Width of the software-visible MSB word.
    localparam int MSB_WIDTH = 32;

endpackage : roachf_mcnt_pkg
`default_nettype wire

// File: rtl/gpu_mcnt_gen.sv
`default_nettype none
//==============================================================================
// Module      : gpu_mcnt_gen
// Description : Master-counter (mcnt) generator for the GPU packetizer.
//               After a software arm edge, the next sync pulse zeroes the
//               counter; from then on every SPEC_LEN valid_in cycles form
//               one spectrum and advance mcnt by one.
//
// Ports
//   user_clk      in   fabric clock, rising edge
//   user_rst      in   synchronous active-high reset
//   sync_in       in   one-cycle sync pulse from the sync generator
//   valid_in      in   one spectrum frame (4 channels) present this cycle
//   arm           in   software arm level; a rising edge arms the block
//   mcnt_out      out  current spectrum count
//   mcnt_valid    out  one-cycle pulse when mcnt_out takes a new value
//   sync_out      out  accepted sync, delayed one cycle
//   user_data_out out  top 32 bits of mcnt_out, for the software register
//   armed         out  high while waiting for the sync that starts counting
//   sync_err      out  sticky: a sync landed off a spectrum boundary in RUN
//
// Revision    : 1.0 - initial release
//==============================================================================
module gpu_mcnt_gen
    import roachf_mcnt_pkg::*;
#(
    parameter int SPEC_LEN   = SPEC_LEN_DEFAULT,
    parameter int MCNT_WIDTH = MCNT_WIDTH_DEFAULT
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  sync_in,
    input  logic                  valid_in,
    input  logic                  arm,
    output logic [MCNT_WIDTH-1:0] mcnt_out,
    output logic                  mcnt_valid,
    output logic                  sync_out,
    output logic [MSB_WIDTH-1:0]  user_data_out,
    output logic                  armed,
    output logic                  sync_err
);

    localparam int SUB_W = (SPEC_LEN > 1) ? $clog2(SPEC_LEN) : 1;
    localparam logic [SUB_W-1:0] C_SUB_LAST = SUB_W'(SPEC_LEN - 1);
    localparam logic [SUB_W-1:0] C_SUB_ONE  = SUB_W'(1);

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    mcnt_state_t           r_state;
    logic                  r_arm_d;
    logic [SUB_W-1:0]      r_sub;
    logic [MCNT_WIDTH-1:0] r_mcnt;
    logic                  r_mcnt_valid;
    logic                  r_sync_out;
    logic                  r_sync_err;
    // Set once the first sync has been accepted. A re-arm from RUN keeps
    // counting while it waits for the new sync; an arm from IDLE (fresh
    // after reset) has nothing meaningful to count yet and stays frozen.
    logic                  r_counting;

    //--------------------------------------------------------------------------
    // Combinational
    //--------------------------------------------------------------------------
    mcnt_state_t w_state_nxt;
    logic        w_arm_edge;
    logic        w_accept_sync;
    logic        w_count_en;
    logic        w_boundary;
    logic        w_off_boundary_sync;

    // arm_d tracks arm during reset as well, so a level held high through
    // reset does not look like an edge once reset drops.
    assign w_arm_edge = arm & ~r_arm_d;

    always_ff @(posedge user_clk) begin
        r_arm_d <= arm;
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic. An arm edge always wins over a coincident sync
    // in IDLE/RUN; the sync is simply dropped and a later one is required.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm_edge) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (sync_in) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_arm_edge) w_state_nxt = ST_ARMED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: state-decoded outputs and qualifiers
    //--------------------------------------------------------------------------
    always_comb begin
        armed               = 1'b0;
        w_accept_sync       = 1'b0;
        w_count_en          = 1'b0;
        w_off_boundary_sync = 1'b0;
        case (r_state)
            ST_ARMED: begin
                armed         = 1'b1;
                w_accept_sync = sync_in;
                w_count_en    = r_counting;
            end
            ST_RUN: begin
                w_count_en          = 1'b1;
                w_off_boundary_sync = sync_in & ~w_arm_edge & (r_sub != '0);
            end
            default: ;
        endcase
    end

    assign w_boundary = w_count_en & valid_in & (r_sub == C_SUB_LAST);

    //--------------------------------------------------------------------------
    // Counters and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_sub        <= '0;
            r_mcnt       <= '0;
            r_mcnt_valid <= 1'b0;
            r_sync_out   <= 1'b0;
            r_sync_err   <= 1'b0;
            r_counting   <= 1'b0;
        end else begin
            r_mcnt_valid <= 1'b0;
            r_sync_out   <= w_accept_sync;

            if (w_accept_sync) begin
                // The frame arriving with the sync is the first of spectrum 0.
                r_mcnt     <= '0;
                r_sub      <= valid_in ? C_SUB_ONE : '0;
                r_sync_err <= 1'b0;
                r_counting <= 1'b1;
            end else begin
                if (w_off_boundary_sync) begin
                    r_sync_err <= 1'b1;
                end
                if (w_count_en && valid_in) begin
                    if (w_boundary) begin
                        r_sub        <= '0;
                        r_mcnt       <= r_mcnt + 1'b1;
                        r_mcnt_valid <= 1'b1;
                    end else begin
                        r_sub <= r_sub + C_SUB_ONE;
                    end
                end
            end
        end
    end

    assign mcnt_out      = r_mcnt;
    assign mcnt_valid    = r_mcnt_valid;
    assign sync_out      = r_sync_out;
    assign sync_err      = r_sync_err;
    // Same register as mcnt_out, so the MSB word and low bits never tear.
    assign user_data_out = r_mcnt[MCNT_WIDTH-1 -: MSB_WIDTH];

endmodule : gpu_mcnt_gen
`default_nettype wire

// File: tb/tb_gpu_mcnt_gen.sv
`default_nettype none
//==============================================================================
// Module      : tb_gpu_mcnt_gen
// Description : Directed self-checking bench for gpu_mcnt_gen with
//               SPEC_LEN = 4 and MCNT_WIDTH = 40.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_gpu_mcnt_gen;

    localparam int SPEC_LEN   = 4;
    localparam int MCNT_WIDTH = 40;

    logic                  clk;
    logic                  rst;
    logic                  sync_in;
    logic                  valid_in;
    logic                  arm;
    logic [MCNT_WIDTH-1:0] mcnt_out;
    logic                  mcnt_valid;
    logic                  sync_out;
    logic [31:0]           user_data_out;
    logic                  armed;
    logic                  sync_err;

    int n_checks = 0;
    int n_errors = 0;

    gpu_mcnt_gen #(
        .SPEC_LEN   (SPEC_LEN),
        .MCNT_WIDTH (MCNT_WIDTH)
    ) dut (
        .user_clk      (clk),
        .user_rst      (rst),
        .sync_in       (sync_in),
        .valid_in      (valid_in),
        .arm           (arm),
        .mcnt_out      (mcnt_out),
        .mcnt_valid    (mcnt_valid),
        .sync_out      (sync_out),
        .user_data_out (user_data_out),
        .armed         (armed),
        .sync_err      (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set before the call are sampled on this edge,
    // and outputs are looked at 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mcnt"},  64'(mcnt_out),      64'h0);
        check({tag, "_mval"},  64'(mcnt_valid),    64'h0);
        check({tag, "_sout"},  64'(sync_out),      64'h0);
        check({tag, "_udata"}, 64'(user_data_out), 64'h0);
        check({tag, "_armed"}, 64'(armed),         64'h0);
        check({tag, "_serr"},  64'(sync_err),      64'h0);
    endtask

    initial begin
        rst      = 1'b1;
        sync_in  = 1'b0;
        valid_in = 1'b0;
        arm      = 1'b0;

        // 1. Reset, then sync/valid without arming: nothing moves.
        steps(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        sync_in  = 1'b1;
        valid_in = 1'b1;
        step();
        sync_in = 1'b0;
        steps(5);
        check_idle_outputs("noarm");

        // 2. Arm, sync, count.
        valid_in = 1'b0;
        arm = 1'b1;
        step();
        check("arm_armed", 64'(armed), 64'h1);
        sync_in  = 1'b1;
        valid_in = 1'b1;
        step();                                  // sync accepted, sub -> 1
        sync_in = 1'b0;
        check("sync_sout",  64'(sync_out), 64'h1);
        check("sync_mcnt",  64'(mcnt_out), 64'h0);
        check("sync_armed", 64'(armed),    64'h0);
        step();                                  // sub -> 2
        check("sync_sout_once", 64'(sync_out),   64'h0);
        check("cnt0_mval",      64'(mcnt_valid), 64'h0);
        steps(2);                                // sub 3, then boundary
        check("cnt1_mcnt", 64'(mcnt_out),   64'h1);
        check("cnt1_mval", 64'(mcnt_valid), 64'h1);
        step();
        check("cnt1_mval_pulse", 64'(mcnt_valid), 64'h0);
        check("cnt1_hold",       64'(mcnt_out),   64'h1);
        steps(3);
        check("cnt2_mcnt",  64'(mcnt_out),      64'h2);
        check("cnt2_mval",  64'(mcnt_valid),    64'h1);
        check("cnt2_udata", 64'(user_data_out), 64'h0);

        // 3. Wrap from all-ones (sub is 0 here).
        valid_in = 1'b0;
        force dut.r_mcnt = 40'hFF_FFFF_FFFF;
        step();
        release dut.r_mcnt;
        step();
        check("wrap_pre_mcnt",  64'(mcnt_out),      64'hFF_FFFF_FFFF);
        check("wrap_pre_udata", 64'(user_data_out), 64'hFFFF_FFFF);
        valid_in = 1'b1;
        steps(3);
        check("wrap_mid_mcnt", 64'(mcnt_out), 64'hFF_FFFF_FFFF);
        step();
        check("wrap_mcnt",  64'(mcnt_out),      64'h0);
        check("wrap_mval",  64'(mcnt_valid),    64'h1);
        check("wrap_udata", 64'(user_data_out), 64'h0);

        // 4. Off-boundary sync sets sync_err; counting unaffected.
        steps(2);                                // sub = 2
        valid_in = 1'b0;
        sync_in  = 1'b1;
        step();
        sync_in = 1'b0;
        check("offb_serr", 64'(sync_err), 64'h1);
        check("offb_sout", 64'(sync_out), 64'h0);
        check("offb_mcnt", 64'(mcnt_out), 64'h0);
        valid_in = 1'b1;
        steps(2);                                // sub 3, then boundary
        check("offb_cnt_mcnt", 64'(mcnt_out),   64'h1);
        check("offb_cnt_mval", 64'(mcnt_valid), 64'h1);
        check("offb_sticky",   64'(sync_err),   64'h1);
        valid_in = 1'b0;
        arm = 1'b0;
        step();
        arm = 1'b1;
        step();
        check("rearm_armed", 64'(armed),    64'h1);
        check("rearm_serr",  64'(sync_err), 64'h1);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("rearm_serr_clr", 64'(sync_err), 64'h0);
        check("rearm_sout",     64'(sync_out), 64'h1);
        check("rearm_mcnt",     64'(mcnt_out), 64'h0);

        // 5. Arm edge coincident with sync in RUN: arm wins, no reset.
        valid_in = 1'b1;
        steps(5);                                // mcnt 1, sub 1
        check("sim_pre_mcnt", 64'(mcnt_out), 64'h1);
        valid_in = 1'b0;
        arm = 1'b0;
        step();
        arm     = 1'b1;
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("sim_armed", 64'(armed),    64'h1);
        check("sim_sout",  64'(sync_out), 64'h0);
        check("sim_mcnt",  64'(mcnt_out), 64'h1);
        check("sim_serr",  64'(sync_err), 64'h0);
        step();
        check("sim_hold", 64'(mcnt_out), 64'h1);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("sim_next_sout",  64'(sync_out), 64'h1);
        check("sim_next_mcnt",  64'(mcnt_out), 64'h0);
        check("sim_next_armed", 64'(armed),    64'h0);

        // 6. Reset mid-run with arm held high.
        valid_in = 1'b1;
        steps(4);
        check("mid_pre_mcnt", 64'(mcnt_out), 64'h1);
        rst = 1'b1;
        step();
        check_idle_outputs("midrst");
        rst = 1'b0;
        steps(2);
        check("midrst_noedge", 64'(armed), 64'h0);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("midrst_sout", 64'(sync_out), 64'h0);
        check("midrst_mcnt", 64'(mcnt_out), 64'h0);
        arm = 1'b0;
        step();
        arm = 1'b1;
        step();
        check("midrst_rearm", 64'(armed), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_gpu_mcnt_gen
`default_nettype wire
